// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace capture path.
//   TRACE_DEPTH_DEFAULT : default number of FIFO entries
//   TRACE_DROP_W        : default width of the dropped-capture counter
//   trace_entry_t       : one captured commit, {pc, data}
package trace_pkg;

    localparam int TRACE_DEPTH_DEFAULT = 16;
    localparam int TRACE_DROP_W        = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo_ram.sv
// DEPTH x 64-bit storage for the commit trace FIFO.
// Synchronous write port, asynchronous read port (maps onto LUT RAM), so the
// entry at a freshly updated read address is visible in the same cycle.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word {pc, data}
//   raddr : read address
//   rdata : word stored at raddr (combinational)
module trace_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    // NOTE: the array has no reset; occupancy tracking guarantees no stale
    // word is ever presented, and a reset would block LUT-RAM mapping.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records {fetch PC, write-back data} for every cycle the
// write-back stage commits a register write, and hands entries to a debug
// consumer through a first-word-fall-through valid/ready interface.
// Captures that arrive while full (with no pop that cycle) are dropped,
// flagged on the sticky Overflow output and counted in DropCount.
//   Clock, Reset_n          : clock and synchronous active-low reset
//   Capture, PC_In,
//   WriteData_In            : commit strobe and the values to record
//   Out_Ready               : consumer takes the head entry this cycle
//   Out_Valid, Out_PC,
//   Out_Data                : head entry (PC/data read as 0 while empty)
//   Count, Full, Empty      : occupancy after the last edge
//   Overflow, DropCount     : sticky drop flag and saturating drop count
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int  DEPTH  = TRACE_DEPTH_DEFAULT,
    parameter int  DROP_W = TRACE_DROP_W,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Capture,
    input  logic [31:0]       PC_In,
    input  logic [31:0]       WriteData_In,
    input  logic              Out_Ready,
    output logic              Out_Valid,
    output logic [31:0]       Out_PC,
    output logic [31:0]       Out_Data,
    output logic [AW:0]       Count,
    output logic              Full,
    output logic              Empty,
    output logic              Overflow,
    output logic [DROP_W-1:0] DropCount
);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_q;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_q;

    logic              push;
    logic              pop;
    logic              drop;
    trace_entry_t      wr_entry;
    trace_entry_t      head;
    logic [63:0]       rd_word;

    // Status is a pure function of the occupancy counter.
    assign Count     = count_q;
    assign Full      = (count_q == (AW+1)'(DEPTH));
    assign Empty     = (count_q == '0);
    assign Out_Valid = !Empty;
    assign Overflow  = overflow_q;
    assign DropCount = drop_q;

    // A pop frees a slot in the same cycle, so a full buffer still accepts
    // a capture when the consumer drains one entry.
    assign pop  = Out_Valid && Out_Ready;
    assign push = Capture && (!Full || pop);
    assign drop = Capture && Full && !pop;

    assign wr_entry = '{pc: PC_In, data: WriteData_In};
    assign head     = trace_entry_t'(rd_word);

    // The RAM word at rd_ptr is undefined while empty; mask it to zero.
    assign Out_PC   = Empty ? 32'd0 : head.pc;
    assign Out_Data = Empty ? 32'd0 : head.data;

    trace_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (Clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            // Pointers are AW bits wide and wrap naturally at DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH    = TRACE_DEPTH_DEFAULT;
    localparam int AW       = $clog2(DEPTH);
    localparam int DROP_W   = TRACE_DROP_W;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic              Capture;
    logic [31:0]       PC_In;
    logic [31:0]       WriteData_In;
    logic              Out_Ready;
    logic              Out_Valid;
    logic [31:0]       Out_PC;
    logic [31:0]       Out_Data;
    logic [AW:0]       Count;
    logic              Full;
    logic              Empty;
    logic              Overflow;
    logic [DROP_W-1:0] DropCount;

    commit_trace_buffer dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Capture      (Capture),
        .PC_In        (PC_In),
        .WriteData_In (WriteData_In),
        .Out_Ready    (Out_Ready),
        .Out_Valid    (Out_Valid),
        .Out_PC       (Out_PC),
        .Out_Data     (Out_Data),
        .Count        (Count),
        .Full         (Full),
        .Empty        (Empty),
        .Overflow     (Overflow),
        .DropCount    (DropCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          cyc;   // cycle index from which the entry should be visible
    } item_t;

    // Reference model: an ideal bounded queue plus drop bookkeeping.
    item_t ref_q[$];
    int    ref_drops = 0;
    bit    ref_ovf   = 1'b0;

    // Scoreboard: entries the consumer should receive, in order.
    item_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    bit stream_mode = 1'b0;

    always @(posedge Clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every handshake the DUT presents must match the scoreboard head.
    always @(negedge Clock) begin
        item_t it;
        if (Reset_n === 1'b1 && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor_pop: got handshake with pc 0x%0h, expected no entry", Out_PC);
            end else begin
                it = exp_q.pop_front();
                check("mon_pc", Out_PC, it.pc);
                check("mon_data", Out_Data, it.data);
                if (stream_mode) check("mon_latency", cycle, it.cyc);
            end
        end
    end

    task automatic check_status();
        check("count", Count, ref_q.size());
        check("full", Full, ref_q.size() == DEPTH);
        check("empty", Empty, ref_q.size() == 0);
        check("valid", Out_Valid, ref_q.size() != 0);
        check("overflow", Overflow, ref_ovf);
        check("dropcount", DropCount, ref_drops);
        if (ref_q.size() == 0) begin
            check("empty_pc", Out_PC, 0);
            check("empty_data", Out_Data, 0);
        end else begin
            check("head_pc", Out_PC, ref_q[0].pc);
            check("head_data", Out_Data, ref_q[0].data);
        end
    endtask

    // One clock: apply inputs, check pre-edge state, advance the model.
    task automatic step(input bit cap, input logic [31:0] pc, input logic [31:0] data, input bit rdy);
        bit    mpop;
        bit    mfull;
        item_t it;
        Capture      = cap;
        PC_In        = pc;
        WriteData_In = data;
        Out_Ready    = rdy;
        @(negedge Clock);
        check_status();
        mpop  = (ref_q.size() > 0) && rdy;
        mfull = (ref_q.size() == DEPTH);
        if (mpop) void'(ref_q.pop_front());
        if (cap && (!mfull || mpop)) begin
            it = '{pc, data, cycle + 1};
            ref_q.push_back(it);
            exp_q.push_back(it);
        end else if (cap) begin
            ref_ovf = 1'b1;
            if (ref_drops < DROP_MAX) ref_drops++;
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset(input bit cap, input bit rdy);
        Reset_n      = 1'b0;
        Capture      = cap;
        Out_Ready    = rdy;
        PC_In        = $urandom;
        WriteData_In = $urandom;
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        ref_q.delete();
        exp_q.delete();
        ref_drops = 0;
        ref_ovf   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && ref_q.size() > 0; i++) step(1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) step(1'b1, base + 32'(4 * i), $urandom, 1'b0);
    endtask

    initial begin
        Reset_n = 1'b0; Capture = 1'b0; Out_Ready = 1'b0;
        PC_In = '0; WriteData_In = '0;
        do_reset(1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);

        // Three captures held, then drained in order.
        step(1'b1, 32'h00, 32'hA, 1'b0);
        step(1'b1, 32'h04, 32'hB, 1'b0);
        step(1'b1, 32'h08, 32'hC, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        drain();

        // Fill, two drops, drain the original sixteen.
        fill(DEPTH, 32'h100);
        step(1'b1, 32'hDEAD0, 32'h1, 1'b0);
        step(1'b1, 32'hDEAD4, 32'h2, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        drain();

        // Full with simultaneous capture and pop.
        fill(DEPTH, 32'h200);
        step(1'b1, 32'h40, 32'h4040, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        drain();

        // Streaming push+pop every cycle; pointers wrap twice.
        stream_mode = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1, 32'h1000 + 32'(4 * i), $urandom, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        stream_mode = 1'b0;
        step(1'b0, 32'd0, 32'd0, 1'b0);

        // Random traffic with alternating drain pressure.
        for (int i = 0; i < 400; i++) begin
            bit rdy;
            rdy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(1'(($urandom_range(0, 2)) != 0), $urandom, $urandom, rdy);
        end
        drain();

        // Reset with five entries queued and Overflow set.
        fill(5, 32'h300);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 32'h500, 32'h55, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        drain();

        // Drop counter saturation.
        fill(DEPTH, 32'h400);
        for (int i = 0; i < DROP_MAX + 5; i++) step(1'b1, 32'hBAD, 32'hBAD, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        check("drop_saturated", DropCount, 64'hFFFF);
        drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
